// File: rtl/if_host_link.sv
// ---------------------------------------------------------------------------
// if_host_link
// Host-side (FPGA) end of the chip's parallel port link. When the chip raises
// config_req, the host selects it, latches the 4-bit transfer code the chip
// presents, then either streams BURST_LEN words from host memory to the chip,
// or captures BURST_LEN words from the chip into a host sink. An illegal code
// skips the data phase and sets a sticky error flag.
//
// Ports
//   clk         link clock (shared with the chip port side)
//   Reset       synchronous, active-high reset
//   config_req  chip request level
//   spi_cs_n    chip select, active low
//   spi_dout    host-to-chip data word
//   spi_dval    spi_dout valid this cycle
//   spi_doe     1 = host drives the bus, 0 = chip drives the bus
//   spi_din     chip-to-host data; bits [3:0] carry the transfer code
//   tx_data     host source word
//   tx_val      host source word valid
//   tx_rdy      source word accepted when tx_val && tx_rdy
//   tx_cmd      latched transfer code (host memory select)
//   rx_data     captured chip word
//   rx_val      rx_data valid (no backpressure)
//   cmd_val     one-cycle pulse when a legal code is latched
//   busy        link is not idle
//   err_cmd     sticky illegal-code flag
// ---------------------------------------------------------------------------
module if_host_link #(
    parameter int PORT_DW   = 128,
    parameter int BURST_LEN = 64,
    parameter int GAP_CYC   = 2
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               config_req,
    output logic               spi_cs_n,
    output logic [PORT_DW-1:0] spi_dout,
    output logic               spi_dval,
    output logic               spi_doe,
    input  logic [PORT_DW-1:0] spi_din,
    input  logic [PORT_DW-1:0] tx_data,
    input  logic               tx_val,
    output logic               tx_rdy,
    output logic [3:0]         tx_cmd,
    output logic [PORT_DW-1:0] rx_data,
    output logic               rx_val,
    output logic               cmd_val,
    output logic               busy,
    output logic               err_cmd
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    localparam logic [CW-1:0] WORD_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] LAST_WORD = CW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1'b1);
    localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        CMD   = 3'd2,
        TX    = 3'd3,
        FLUSH = 3'd4,
        TURN  = 3'd5,
        RX    = 3'd6,
        GAP   = 3'd7
    } state_t;

    // Host-to-chip codes: CFG, FLGWEI, WEI, FLGACT, ACT.
    function automatic logic isTxCode(input logic [3:0] code);
        logic hit;
        case (code)
            4'd0, 4'd8, 4'd6, 4'd4, 4'd2: hit = 1'b1;
            default:                      hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Chip-to-host codes: FLGOFM, OFM.
    function automatic logic isRxCode(input logic [3:0] code);
        logic hit;
        case (code)
            4'd10, 4'd11: hit = 1'b1;
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

    state_t             state;
    state_t             stateNext;
    logic [CW-1:0]      wordCnt;
    logic [CW-1:0]      wordCntNext;
    logic [GW-1:0]      gapCnt;
    logic [GW-1:0]      gapCntNext;
    logic               csNNext;
    logic [PORT_DW-1:0] doutNext;
    logic               dvalNext;
    logic               doeNext;
    logic [3:0]         cmdNext;
    logic [PORT_DW-1:0] rxDataNext;
    logic               rxValNext;
    logic               cmdValNext;
    logic               errNext;

    // Source handshake is only open while streaming words to the chip.
    assign tx_rdy = (state == TX);

    // Next-state and next-output decode; pulses default low, data holds.
    always_comb begin
        stateNext   = state;
        wordCntNext = wordCnt;
        gapCntNext  = gapCnt;
        csNNext     = spi_cs_n;
        doutNext    = spi_dout;
        dvalNext    = 1'b0;
        doeNext     = spi_doe;
        cmdNext     = tx_cmd;
        rxDataNext  = rx_data;
        rxValNext   = 1'b0;
        cmdValNext  = 1'b0;
        errNext     = err_cmd;

        case (state)
            IDLE: begin
                if (config_req) begin
                    stateNext = SEL;
                    csNNext   = 1'b0;
                end else begin
                    stateNext = IDLE;
                end
            end
            SEL: begin
                // Chip registers its code onto spi_din during this cycle.
                stateNext = CMD;
            end
            CMD: begin
                cmdNext     = spi_din[3:0];
                wordCntNext = {CW{1'b0}};
                gapCntNext  = {GW{1'b0}};
                if (isTxCode(spi_din[3:0])) begin
                    stateNext  = TX;
                    cmdValNext = 1'b1;
                end else if (isRxCode(spi_din[3:0])) begin
                    stateNext  = TURN;
                    doeNext    = 1'b0;
                    cmdValNext = 1'b1;
                end else begin
                    stateNext = GAP;
                    errNext   = 1'b1;
                    csNNext   = 1'b1;
                end
            end
            TX: begin
                if (tx_val) begin
                    doutNext    = tx_data;
                    dvalNext    = 1'b1;
                    wordCntNext = wordCnt + WORD_ONE;
                    if (wordCnt == LAST_WORD) begin
                        stateNext = FLUSH;
                    end else begin
                        stateNext = TX;
                    end
                end else begin
                    // Source stall: chip select stays low, no word this cycle.
                    stateNext = TX;
                end
            end
            FLUSH: begin
                // Last word is on the bus now; deselect after it.
                stateNext  = GAP;
                csNNext    = 1'b1;
                gapCntNext = {GW{1'b0}};
            end
            TURN: begin
                stateNext = RX;
            end
            RX: begin
                rxDataNext  = spi_din;
                rxValNext   = 1'b1;
                wordCntNext = wordCnt + WORD_ONE;
                if (wordCnt == LAST_WORD) begin
                    stateNext  = GAP;
                    csNNext    = 1'b1;
                    doeNext    = 1'b1;
                    gapCntNext = {GW{1'b0}};
                end else begin
                    stateNext = RX;
                end
            end
            GAP: begin
                // config_req is deliberately not looked at here.
                if (gapCnt == LAST_GAP) begin
                    stateNext = IDLE;
                end else begin
                    gapCntNext = gapCnt + GAP_ONE;
                end
            end
            default: begin
                stateNext = IDLE;
                csNNext   = 1'b1;
                doeNext   = 1'b1;
            end
        endcase
    end

    // State, counters and all registered outputs; Reset overrides any burst.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= IDLE;
            wordCnt  <= {CW{1'b0}};
            gapCnt   <= {GW{1'b0}};
            spi_cs_n <= 1'b1;
            spi_dout <= {PORT_DW{1'b0}};
            spi_dval <= 1'b0;
            spi_doe  <= 1'b1;
            tx_cmd   <= 4'd0;
            rx_data  <= {PORT_DW{1'b0}};
            rx_val   <= 1'b0;
            cmd_val  <= 1'b0;
            busy     <= 1'b0;
            err_cmd  <= 1'b0;
        end else begin
            state    <= stateNext;
            wordCnt  <= wordCntNext;
            gapCnt   <= gapCntNext;
            spi_cs_n <= csNNext;
            spi_dout <= doutNext;
            spi_dval <= dvalNext;
            spi_doe  <= doeNext;
            tx_cmd   <= cmdNext;
            rx_data  <= rxDataNext;
            rx_val   <= rxValNext;
            cmd_val  <= cmdValNext;
            busy     <= (stateNext != IDLE);
            err_cmd  <= errNext;
        end
    end

endmodule

// File: tb/tb_if_host_link.sv
// ---------------------------------------------------------------------------
// tb_if_host_link
// Self-checking bench for if_host_link. Each burst is described by its code,
// its data words and a per-cycle tx_val plan; the expected waveform of every
// output is derived from the link's timing rules (select, code cycle, data
// phase, gap, idle sample) with plain cycle arithmetic.
// ---------------------------------------------------------------------------
module tb_if_host_link;

    localparam int DW = 32;
    localparam int BL = 4;
    localparam int GC = 2;

    logic          clk = 1'b0;
    logic          Reset;
    logic          config_req;
    logic          spi_cs_n;
    logic [DW-1:0] spi_dout;
    logic          spi_dval;
    logic          spi_doe;
    logic [DW-1:0] spi_din;
    logic [DW-1:0] tx_data;
    logic          tx_val;
    logic          tx_rdy;
    logic [3:0]    tx_cmd;
    logic [DW-1:0] rx_data;
    logic          rx_val;
    logic          cmd_val;
    logic          busy;
    logic          err_cmd;

    int            testCnt = 0;
    int            failCnt = 0;
    logic [DW-1:0] txWords [BL];
    logic [DW-1:0] rxWords [BL];
    bit            valPlan [64];
    bit            errSticky = 1'b0;
    logic [3:0]    lastCmd = 4'd0;
    int            cyc = 0;
    bit            prevCs = 1'b1;
    int            fallCyc [$];

    always #5 clk = ~clk;

    if_host_link #(.PORT_DW(DW), .BURST_LEN(BL), .GAP_CYC(GC)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .config_req (config_req),
        .spi_cs_n   (spi_cs_n),
        .spi_dout   (spi_dout),
        .spi_dval   (spi_dval),
        .spi_doe    (spi_doe),
        .spi_din    (spi_din),
        .tx_data    (tx_data),
        .tx_val     (tx_val),
        .tx_rdy     (tx_rdy),
        .tx_cmd     (tx_cmd),
        .rx_data    (rx_data),
        .rx_val     (rx_val),
        .cmd_val    (cmd_val),
        .busy       (busy),
        .err_cmd    (err_cmd)
    );

    // Records the cycle number of every chip-select falling edge.
    always @(negedge clk) begin
        cyc    <= cyc + 1;
        prevCs <= spi_cs_n;
        if (prevCs && !spi_cs_n) fallCyc.push_back(cyc);
    end

    // 0 = host->chip, 1 = chip->host, 2 = illegal
    function automatic int codeKind(input logic [3:0] c);
        case (c)
            4'd0, 4'd8, 4'd6, 4'd4, 4'd2: return 0;
            4'd10, 4'd11:                 return 1;
            default:                      return 2;
        endcase
    endfunction

    task automatic chk1(input string tag, input int j, input logic obs, input logic exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, j, obs, exp);
        end
    endtask

    task automatic chkW(input string tag, input int j, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, j, obs, exp);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int exp);
        testCnt++;
        assert (obs == exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkReset(input int j);
        chk1("rst_cs_n", j, spi_cs_n, 1'b1);
        chk1("rst_doe", j, spi_doe, 1'b1);
        chk1("rst_dval", j, spi_dval, 1'b0);
        chk1("rst_tx_rdy", j, tx_rdy, 1'b0);
        chk1("rst_rx_val", j, rx_val, 1'b0);
        chk1("rst_cmd_val", j, cmd_val, 1'b0);
        chk1("rst_err", j, err_cmd, 1'b0);
        chk1("rst_busy", j, busy, 1'b0);
        chkW("rst_dout", j, spi_dout, '0);
        chkW("rst_rx_data", j, rx_data, '0);
        chkW("rst_tx_cmd", j, {{(DW-4){1'b0}}, tx_cmd}, '0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            config_req = 1'b0;
            @(negedge clk);
            chk1("idle_cs_n", i, spi_cs_n, 1'b1);
            chk1("idle_busy", i, busy, 1'b0);
        end
    endtask

    task automatic setPlan(input int stallStart, input int stallLen);
        for (int j = 0; j < 64; j++)
            valPlan[j] = !(j >= stallStart && j < stallStart + stallLen);
    endtask

    // Runs one request starting from an IDLE cycle; returns on the IDLE cycle
    // after the gap (or right after Reset when abortJ is reached).
    task automatic runBurst(input logic [3:0] code, input bit hold, input int abortJ);
        int kind, jl, lowEnd, busyEnd, idleJ, acc, k;
        bit expDval, expRxv, inWin;
        kind = codeKind(code);
        jl   = 0;
        acc  = 0;
        if (kind == 0) begin
            for (int j = 3; j < 64; j++) begin
                if (valPlan[j]) acc++;
                if (acc == BL) begin
                    jl = j;
                    break;
                end
            end
        end
        lowEnd  = (kind == 0) ? jl + 1 : (kind == 1) ? 3 + BL : 2;
        busyEnd = lowEnd + GC;
        idleJ   = busyEnd + 1;
        acc = 0;
        k   = 0;
        config_req = 1'b1;
        for (int j = 1; j <= idleJ; j++) begin
            @(negedge clk);
            chk1("spi_cs_n", j, spi_cs_n, !(j <= lowEnd));
            chk1("busy", j, busy, j <= busyEnd);
            chk1("tx_rdy", j, tx_rdy, kind == 0 && j >= 3 && j <= jl);
            expDval = (kind == 0) && (j - 1 >= 3) && (j - 1 <= jl) && valPlan[j-1];
            chk1("spi_dval", j, spi_dval, expDval);
            if (expDval) begin
                chkW("spi_dout", j, spi_dout, txWords[k]);
                k++;
            end
            chk1("spi_doe", j, spi_doe, !(kind == 1 && j >= 3 && j <= lowEnd));
            chk1("cmd_val", j, cmd_val, kind != 2 && j == 3);
            chkW("tx_cmd", j, {{(DW-4){1'b0}}, tx_cmd}, {{(DW-4){1'b0}}, (j >= 3) ? code : lastCmd});
            expRxv = (kind == 1) && j >= 5 && j <= 4 + BL;
            chk1("rx_val", j, rx_val, expRxv);
            if (expRxv) chkW("rx_data", j, rx_data, rxWords[j-5]);
            chk1("err_cmd", j, err_cmd, errSticky || (kind == 2 && j >= 3));
            if (j == abortJ) begin
                Reset      = 1'b1;
                config_req = 1'b0;
                tx_val     = 1'b1;
                tx_data    = $urandom;
                @(negedge clk);
                chkReset(j + 1);
                Reset     = 1'b0;
                errSticky = 1'b0;
                lastCmd   = 4'd0;
                return;
            end
            config_req = hold;
            spi_din    = $urandom;
            if (j == 2) spi_din[3:0] = code;
            if (kind == 1 && j >= 4 && j <= 3 + BL) spi_din = rxWords[j-4];
            inWin = (kind == 0) && j >= 3 && j <= jl;
            if (inWin && valPlan[j]) begin
                tx_val  = 1'b1;
                tx_data = txWords[acc];
                acc++;
            end else begin
                tx_val  = inWin ? 1'b0 : 1'($urandom_range(0, 1));
                tx_data = $urandom;
            end
        end
        lastCmd = code;
        if (kind == 2) errSticky = 1'b1;
    endtask

    initial begin
        int n0;
        logic [3:0] code;
        bit hold;

        // Reset wins over an active request and valid source data.
        Reset      = 1'b1;
        config_req = 1'b1;
        tx_val     = 1'b1;
        tx_data    = '0;
        spi_din    = '0;
        repeat (3) @(negedge clk);
        chkReset(0);
        Reset      = 1'b0;
        tx_val     = 1'b0;
        idleCycles(2);

        // Normal host->chip burst, code 6, words 0x11..0x44.
        for (int i = 0; i < BL; i++) txWords[i] = DW'((i + 1) * 17);
        setPlan(99, 0);
        runBurst(4'd6, 1'b0, 0);
        idleCycles(1);

        // Source stall of 3 cycles after word 2 (words accepted at cycles 3,4).
        for (int i = 0; i < BL; i++) txWords[i] = $urandom;
        setPlan(5, 3);
        runBurst(4'd8, 1'b0, 0);

        // Chip->host burst, code 11, words 0xA0..0xA3.
        for (int i = 0; i < BL; i++) rxWords[i] = DW'(160 + i);
        runBurst(4'd11, 1'b0, 0);
        idleCycles(1);

        // Illegal code 5, then a legal code-2 burst with err_cmd still set.
        runBurst(4'd5, 1'b0, 0);
        for (int i = 0; i < BL; i++) txWords[i] = $urandom;
        setPlan(99, 0);
        runBurst(4'd2, 1'b0, 0);

        // Reset after 2 of 4 words, then a full fresh burst.
        for (int i = 0; i < BL; i++) txWords[i] = $urandom;
        runBurst(4'd0, 1'b0, 5);
        for (int i = 0; i < BL; i++) txWords[i] = $urandom;
        runBurst(4'd4, 1'b0, 0);
        idleCycles(2);

        // Request held high across TX, RX and TX bursts.
        n0 = fallCyc.size();
        for (int i = 0; i < BL; i++) txWords[i] = $urandom;
        for (int i = 0; i < BL; i++) rxWords[i] = $urandom;
        runBurst(4'd6, 1'b1, 0);
        runBurst(4'd10, 1'b1, 0);
        runBurst(4'd0, 1'b0, 0);
        chkInt("cs_fall_count", fallCyc.size() - n0, 3);
        if (fallCyc.size() >= n0 + 3) begin
            chkInt("cs_spacing_tx", fallCyc[n0+1] - fallCyc[n0], (2 + BL) + 1 + GC + 1);
            chkInt("cs_spacing_rx", fallCyc[n0+2] - fallCyc[n0+1], (2 + BL) + 1 + GC + 1);
        end
        idleCycles(1);

        // Random codes, random data, random source stalls, random hold.
        for (int it = 0; it < 10; it++) begin
            code = 4'($urandom_range(0, 15));
            hold = (it != 9) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < BL; i++) txWords[i] = $urandom;
            for (int i = 0; i < BL; i++) rxWords[i] = $urandom;
            for (int j = 0; j < 64; j++) valPlan[j] = (j >= 40) || ($urandom_range(0, 3) != 0);
            runBurst(code, hold, 0);
        end
        idleCycles(2);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
